// File: rtl/datapath_pipelined.sv
// datapath_pipelined: 2-stage (D: issue/PC, E: ALU/branch/writeback) datapath with stall, flush and RAW handling.
// Build option: define DP_FWD_EN to bypass the E writeback value into D instead of interlocking.
module datapath_pipelined #(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned PC_W     = 3,
  parameter int unsigned RF_DEPTH = 8,
  parameter int unsigned CONST_W  = 3,
  localparam int unsigned AW      = $clog2(RF_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic               stall,
  input  logic               branch,
  input  logic               reg_wr_sel,
  input  logic [DATA_W-1:0]  mem_rd,
  input  logic               alu_src_sel,
  input  logic [1:0]         alu_op,
  input  logic [AW-1:0]      rf_add1,
  input  logic [AW-1:0]      rf_add2,
  input  logic [AW-1:0]      rf_wa,
  input  logic               rf_we,
  input  logic [CONST_W-1:0] constant,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_next,
  output logic               eq,
  output logic [DATA_W-1:0]  alu_src1,
  output logic [DATA_W-1:0]  alu_src2,
  output logic [DATA_W-1:0]  alu_out,
  output logic               wb_valid,
  output logic               flush,
  output logic               hazard
);

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} alu_op_e;

  logic [DATA_W-1:0]  rf_q [RF_DEPTH];
  logic [PC_W-1:0]    pc_q, pc_d;

  logic               e_valid_q, e_branch_q, e_we_q, e_wrsel_q;
  alu_op_e            e_op_q;
  logic [AW-1:0]      e_wa_q;
  logic [DATA_W-1:0]  e_src1_q, e_src2_q, e_mem_q;
  logic [PC_W-1:0]    e_pc_q;
  logic [CONST_W-1:0] e_const_q;

  logic [DATA_W-1:0]  alu_res, wb_data, rd1, rd2, d_src1_d, d_src2_d;
  logic               e_wr, raw1, raw2, hz, fl, acc;

  always_comb begin
    alu_res = '0;
    unique case (e_op_q)
      OP_ADD: alu_res = e_src1_q + e_src2_q;
      OP_SUB: alu_res = e_src1_q - e_src2_q;
      OP_AND: alu_res = e_src1_q & e_src2_q;
      OP_OR:  alu_res = e_src1_q | e_src2_q;
    endcase
  end

  // Branches never write the RF, so they also never create a RAW dependency.
  assign wb_data = e_wrsel_q ? e_mem_q : alu_res;
  assign e_wr    = e_valid_q & e_we_q & ~e_branch_q;
  assign fl      = e_valid_q & e_branch_q & (e_src1_q == e_src2_q);

  assign rd1  = rf_q[rf_add1];
  assign rd2  = rf_q[rf_add2];
  assign raw1 = e_wr & (rf_add1 == e_wa_q);
  assign raw2 = e_wr & ~alu_src_sel & (rf_add2 == e_wa_q);

`ifdef DP_FWD_EN
  assign hz       = 1'b0;
  assign d_src1_d = raw1 ? wb_data : rd1;
  assign d_src2_d = alu_src_sel ? DATA_W'(constant) : (raw2 ? wb_data : rd2);
`else
  assign hz       = issue_valid & ~fl & (raw1 | raw2);
  assign d_src1_d = rd1;
  assign d_src2_d = alu_src_sel ? DATA_W'(constant) : rd2;
`endif

  assign acc = issue_valid & ~stall & ~hz & ~fl;

  always_comb begin
    pc_d = pc_q;
    if (fl)       pc_d = e_pc_q + PC_W'(e_const_q);
    else if (acc) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      e_valid_q  <= 1'b0;
      e_branch_q <= 1'b0;
      e_we_q     <= 1'b0;
      e_wrsel_q  <= 1'b0;
      e_op_q     <= OP_ADD;
      e_wa_q     <= '0;
      e_src1_q   <= '0;
      e_src2_q   <= '0;
      e_mem_q    <= '0;
      e_pc_q     <= '0;
      e_const_q  <= '0;
      for (int unsigned i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      e_valid_q <= acc;
      if (acc) begin
        e_branch_q <= branch;
        e_we_q     <= rf_we;
        e_wrsel_q  <= reg_wr_sel;
        e_op_q     <= alu_op_e'(alu_op);
        e_wa_q     <= rf_wa;
        e_src1_q   <= d_src1_d;
        e_src2_q   <= d_src2_d;
        e_mem_q    <= mem_rd;
        e_pc_q     <= pc_q;
        e_const_q  <= constant;
      end
      if (e_wr) rf_q[e_wa_q] <= wb_data;
    end
  end

  // eq is qualified by E.valid so an empty E stage (incl. just after reset) reports 0.
  assign pc       = pc_q;
  assign pc_next  = reset ? '0 : pc_d;
  assign eq       = e_valid_q & (e_src1_q == e_src2_q);
  assign alu_src1 = e_src1_q;
  assign alu_src2 = e_src2_q;
  assign alu_out  = alu_res;
  assign wb_valid = e_valid_q;
  assign flush    = fl;
  assign hazard   = hz;

endmodule

// File: tb/tb_datapath_pipelined.sv
// tb_datapath_pipelined: directed scenarios plus $urandom traffic against an instruction-level reference model.
module tb_datapath_pipelined;

  localparam int DW = 4, PW = 3, NR = 8, CW = 3;
  localparam int ND = 1 << DW, NP = 1 << PW;

  logic          clk = 1'b0;
  logic          reset, issue_valid, stall, branch, reg_wr_sel, alu_src_sel, rf_we;
  logic [DW-1:0] mem_rd;
  logic [1:0]    alu_op;
  logic [2:0]    rf_add1, rf_add2, rf_wa;
  logic [CW-1:0] constant;
  logic [PW-1:0] pc, pc_next;
  logic          eq, wb_valid, flush, hazard;
  logic [DW-1:0] alu_src1, alu_src2, alu_out;

  always #5 clk = ~clk;

  datapath_pipelined #(.DATA_W(DW), .PC_W(PW), .RF_DEPTH(NR), .CONST_W(CW)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .stall(stall), .branch(branch),
    .reg_wr_sel(reg_wr_sel), .mem_rd(mem_rd), .alu_src_sel(alu_src_sel), .alu_op(alu_op),
    .rf_add1(rf_add1), .rf_add2(rf_add2), .rf_wa(rf_wa), .rf_we(rf_we), .constant(constant),
    .pc(pc), .pc_next(pc_next), .eq(eq), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_out(alu_out), .wb_valid(wb_valid), .flush(flush), .hazard(hazard)
  );

  typedef struct packed {
    bit rst, iv, st, br, wrsel, srcsel, we;
    bit [1:0] op;
    bit [2:0] a1, a2, wa;
    bit [3:0] mem;
    bit [2:0] k;
  } ins_t;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural RF/PC plus the one instruction in flight, held as its resolved effect.
  int m_rf [NR];
  int m_pc;
  bit e_v, e_wr, e_br;
  int e_s1, e_s2, e_res, e_wa, e_wd, e_tgt;
  bit last_acc;
  int hz_seen;

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = 0;
    m_pc = 0; e_v = 0; e_wr = 0; e_br = 0;
    e_s1 = 0; e_s2 = 0; e_res = 0; e_wa = 0; e_wd = 0; e_tgt = 0;
  endtask

  // Value an in-order machine would read: the in-flight result counts as already written.
  function automatic int arch(input int r);
    return (e_v && e_wr && e_wa == r) ? e_wd : m_rf[r];
  endfunction

  task automatic step(input ins_t t);
    bit eqx, flx, hzx, acc, conf;
    int pcn, s1, s2, res, tgt;
    @(negedge clk);
    reset = t.rst; issue_valid = t.iv; stall = t.st; branch = t.br; reg_wr_sel = t.wrsel;
    alu_src_sel = t.srcsel; rf_we = t.we; alu_op = t.op; rf_add1 = t.a1; rf_add2 = t.a2;
    rf_wa = t.wa; mem_rd = t.mem; constant = t.k;
    #1;
    eqx  = e_v && (e_s1 == e_s2);
    flx  = eqx && e_br;
    conf = e_v && e_wr && (t.a1 == e_wa || (!t.srcsel && t.a2 == e_wa));
`ifdef DP_FWD_EN
    hzx = 1'b0;
`else
    hzx = t.iv && !flx && conf;
`endif
    acc = t.iv && !t.st && !hzx && !flx;
    pcn = t.rst ? 0 : flx ? e_tgt : acc ? (m_pc + 1) % NP : m_pc;
    chk("pc", pc, m_pc);
    chk("pc_next", pc_next, pcn);
    chk("eq", eq, eqx);
    chk("flush", flush, flx);
    chk("hazard", hazard, hzx);
    chk("wb_valid", wb_valid, e_v);
    chk("alu_src1", alu_src1, e_s1);
    chk("alu_src2", alu_src2, e_s2);
    chk("alu_out", alu_out, e_res);
    hz_seen += int'(hazard);
    last_acc = acc;
    s1 = arch(t.a1);
    s2 = t.srcsel ? int'(t.k) : arch(t.a2);
    case (t.op)
      2'd0: res = (s1 + s2) % ND;
      2'd1: res = (s1 - s2 + ND) % ND;
      2'd2: res = s1 & s2;
      default: res = s1 | s2;
    endcase
    tgt = (m_pc + int'(t.k)) % NP;
    @(posedge clk);
    if (t.rst) model_reset();
    else begin
      if (e_v && e_wr) m_rf[e_wa] = e_wd;
      m_pc = pcn;
      e_v = acc;
      if (acc) begin
        e_s1 = s1; e_s2 = s2; e_res = res; e_wa = t.wa; e_br = t.br;
        e_wr = t.we && !t.br; e_wd = t.wrsel ? int'(t.mem) : res; e_tgt = tgt;
      end
    end
    #1;
  endtask

  task automatic issue(input ins_t t);
    for (int n = 0; n < 6; n++) begin
      step(t);
      if (last_acc) return;
    end
    n_vec++; n_err++;
    $display("FAIL issue_timeout: instruction not accepted within 6 cycles (t=%0t)", $time);
  endtask

  function automatic ins_t alu_k(input int wa, input int a1, input int k, input int op);
    ins_t t = '0;
    t.iv = 1; t.we = 1; t.srcsel = 1; t.wa = 3'(wa); t.a1 = 3'(a1); t.k = 3'(k); t.op = 2'(op);
    return t;
  endfunction

  function automatic ins_t alu_r(input int wa, input int a1, input int a2, input int op);
    ins_t t = '0;
    t.iv = 1; t.we = 1; t.wa = 3'(wa); t.a1 = 3'(a1); t.a2 = 3'(a2); t.op = 2'(op);
    return t;
  endfunction

  function automatic ins_t ldm(input int wa, input int v);
    ins_t t = '0;
    t.iv = 1; t.we = 1; t.wrsel = 1; t.srcsel = 1; t.wa = 3'(wa); t.mem = 4'(v);
    return t;
  endfunction

  function automatic ins_t beq(input int a1, input int a2, input int k);
    ins_t t = '0;
    t.iv = 1; t.br = 1; t.we = 1; t.a1 = 3'(a1); t.a2 = 3'(a2); t.k = 3'(k); t.wa = 3'(a1);
    return t;
  endfunction

  function automatic ins_t probe(input int r);
    ins_t t = alu_k(0, r, 0, 0);
    t.we = 0;
    return t;
  endfunction

  function automatic ins_t rst_i();
    ins_t t = '0;
    t.rst = 1;
    return t;
  endfunction

  task automatic read_reg(input string tag, input int r, input int exp);
    issue(probe(r));
    chk(tag, alu_src1, exp);
  endtask

  task automatic advance_to(input int target_pc);
    for (int n = 0; n < NP && m_pc != target_pc; n++) issue(probe(0));
  endtask

  initial begin
    ins_t t, s;
    {reset, issue_valid, stall, branch, reg_wr_sel, alu_src_sel, rf_we} = 7'b1000000;
    {mem_rd, alu_op, rf_add1, rf_add2, rf_wa, constant} = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    hz_seen = 0;

    // Reset with a loaded RF clears everything.
    issue(alu_k(1, 0, 5, 0));
    issue(alu_k(2, 1, 2, 3));
    issue(ldm(6, 11));
    step(rst_i());
    chk("rst_pc", pc, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    for (int r = 0; r < NR; r++) read_reg("rst_rf", r, 0);

    // Back-to-back RAW: r1 = r0+5, r2 = r1+r1.
    step(rst_i());
    issue(alu_k(1, 0, 5, 0));
    hz_seen = 0;
    issue(alu_r(2, 1, 1, 0));
`ifdef DP_FWD_EN
    chk("raw_hazard_cycles", hz_seen, 0);
`else
    chk("raw_hazard_cycles", hz_seen, 1);
`endif
    chk("raw_alu_out", alu_out, 10);
    chk("raw_pc", pc, 2);
    step(probe(0));
    read_reg("raw_r2", 2, 10);

    // Taken beq at pc=2 with const=3 squashes the pc=3 instruction.
    step(rst_i());
    issue(alu_k(1, 0, 3, 0));
    issue(alu_k(2, 0, 3, 0));
    issue(beq(1, 2, 3));
    chk("beq_eq", eq, 1);
    chk("beq_flush", flush, 1);
    step(alu_k(4, 0, 7, 0));
    chk("beq_pc_target", pc, 5);
    chk("beq_squash_wb", wb_valid, 0);
    read_reg("beq_r4_untouched", 4, 0);

    // Arithmetic and PC wrap.
    step(rst_i());
    issue(ldm(1, 9));
    issue(alu_r(2, 1, 1, 0));
    chk("wrap_alu", alu_out, 2);
    advance_to(7);
    issue(probe(0));
    chk("wrap_pc", pc, 0);
    step(rst_i());
    advance_to(6);
    issue(beq(0, 0, 3));
    chk("wrap_beq_flush", flush, 1);
    step('0);
    chk("wrap_beq_pc", pc, 1);

    // Stall holds D/PC while E completes.
    step(rst_i());
    issue(alu_k(3, 0, 6, 0));
    s = alu_k(5, 0, 1, 0);
    s.st = 1;
    for (int n = 0; n < 3; n++) begin
      step(s);
      chk("stall_pc", pc, 1);
      chk("stall_wb_valid", wb_valid, 0);
    end
    issue(alu_k(5, 0, 1, 0));
    read_reg("stall_r3", 3, 6);

    // Reset while E holds a write.
    step(rst_i());
    issue(alu_k(3, 0, 6, 0));
    step(rst_i());
    chk("rst_e_wb_valid", wb_valid, 0);
    read_reg("rst_e_r3", 3, 0);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      t        = '0;
      t.rst    = ($urandom_range(0, 99) == 0);
      t.iv     = ($urandom_range(0, 9) < 8);
      t.st     = ($urandom_range(0, 9) < 2);
      t.br     = ($urandom_range(0, 9) < 2);
      t.wrsel  = ($urandom_range(0, 3) == 0);
      t.srcsel = 1'($urandom);
      t.we     = ($urandom_range(0, 9) < 8);
      t.op     = 2'($urandom);
      t.a1     = 3'($urandom_range(0, 3));
      t.a2     = 3'($urandom_range(0, 3));
      t.wa     = 3'($urandom_range(0, 3));
      t.mem    = 4'($urandom);
      t.k      = 3'($urandom);
      step(t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
